// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the macro-command to micro-opcode sequencer.
// Field widths match the 7-bit opcode bus consumed by the control-word decoder.
package ctrl_pkg;

    localparam int OPC_W  = 7;
    localparam int ID_W   = 3;
    localparam int ARG_W  = 2;
    localparam int STEP_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Burst length 1..4, needs one more bit than the step counter.
    function automatic logic [STEP_W:0] burst_len(input logic [ID_W-1:0] id);
        return {1'b0, id[1:0]} + (STEP_W+1)'(1);
    endfunction

    function automatic logic [OPC_W-1:0] pack_opcode(input logic [ARG_W-1:0]  arg,
                                                     input logic [ID_W-1:0]   id,
                                                     input logic [STEP_W-1:0] step);
        return {arg, id, step};
    endfunction

endpackage

// File: rtl/ctrl_opcode_sequencer.sv
// Expands handshaked macro commands into bursts of 1-4 micro-opcodes, with
// abort support and a saturating count of completed micro-op handshakes.
module ctrl_opcode_sequencer
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ID_W-1:0]  cmd_id,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [OPC_W-1:0] op_code,
    output logic             op_last,
    input  logic             abort,
    output logic             abort_done,
    output logic [CNT_W-1:0] issued_cnt
);

    state_e              state_q, state_d;
    logic                cmd_ready_q;
    logic                abort_done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ID_W-1:0]     id_q;
    logic [ARG_W-1:0]    arg_q;
    logic [STEP_W-1:0]   step_q;

    logic cmd_hs;
    logic op_hs;
    logic last_beat;

    assign op_valid  = (state_q == ISSUE);
    assign cmd_hs    = cmd_valid & cmd_ready_q;
    assign op_hs     = op_valid & op_ready;
    assign last_beat = ({1'b0, step_q} == (burst_len(id_q) - (STEP_W+1)'(1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = ISSUE;
            ISSUE:   if (abort || (op_hs && last_beat)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready is registered so it only rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            abort_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= (state_d == IDLE);
            abort_done_q <= (state_q == ISSUE) && abort;
            if (op_hs && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Command fields are only qualified by op_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            id_q   <= cmd_id;
            arg_q  <= cmd_arg;
            step_q <= '0;
        end else if (op_hs && !last_beat) begin
            step_q <= step_q + STEP_W'(1);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign op_code    = op_valid ? pack_opcode(arg_q, id_q, step_q) : '0;
    assign op_last    = op_valid & last_beat;
    assign abort_done = abort_done_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_opcode_sequencer.sv
// Directed bench for ctrl_opcode_sequencer: expected beats are queued by the
// stimulus and popped by an independent monitor on each op handshake.
module tb_ctrl_opcode_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_id;
    logic [1:0]       cmd_arg;
    logic             op_valid;
    logic             op_ready;
    logic [6:0]       op_code;
    logic             op_last;
    logic             abort;
    logic             abort_done;
    logic [CNT_W-1:0] issued_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];   // {last, code}

    ctrl_opcode_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_arg(cmd_arg),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_last(op_last),
        .abort(abort), .abort_done(abort_done),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] code, input logic last);
        exp_q.push_back({last, code});
    endtask

    task automatic send_cmd(input logic [2:0] id, input logic [1:0] arg);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_arg   = arg;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_ready) done = 1;
            tick();
        end
        cmd_valid = 1'b0;
        cmd_id    = ~id;
        cmd_arg   = ~arg;
        if (!done) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_ready) done = 1;
            else tick();
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    // Monitor: every op handshake must match the next queued beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && op_valid && op_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {op_last, op_code}, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("beat_code", op_code, e[6:0]);
                    check("beat_last", op_last, e[7]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_arg = '0;
        op_ready = 1'b0; abort = 1'b0;
        repeat (2) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_code", op_code, 0);
        check("rst_cnt", issued_cnt, 0);
        check("rst_abort_done", abort_done, 0);
        rst_n = 1'b1;
        check("cmd_ready_before_edge", cmd_ready, 0);
        tick();
        check("cmd_ready_after_edge", cmd_ready, 1);

        // 1: single beat
        op_ready = 1'b1;
        push(7'h00, 1'b1);
        send_cmd(3'd0, 2'd0);
        check("t1_op_valid", op_valid, 1);
        check("t1_cmd_ready_busy", cmd_ready, 0);
        tick();
        check("t1_cmd_ready_back", cmd_ready, 1);
        check("t1_op_valid_low", op_valid, 0);
        check("t1_cnt", issued_cnt, 1);

        // 2: four back-to-back beats
        push(7'h4C, 1'b0); push(7'h4D, 1'b0); push(7'h4E, 1'b0); push(7'h4F, 1'b1);
        send_cmd(3'd3, 2'd2);
        repeat (4) tick();
        check("t2_no_bubble_idle", cmd_ready, 1);
        check("t2_cnt", issued_cnt, 5);

        // 3: backpressure on the second beat
        push(7'h04, 1'b0); push(7'h05, 1'b1);
        send_cmd(3'd1, 2'd0);
        tick();
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", op_valid, 1);
            check("t3_hold_code", op_code, 7'h05);
            check("t3_hold_last", op_last, 1);
            tick();
        end
        op_ready = 1'b1;
        tick();
        check("t3_idle", cmd_ready, 1);
        check("t3_cnt", issued_cnt, 7);

        // abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_no_pulse", abort_done, 0);

        // 4a: abort with no handshake withdraws the pending beat
        push(7'h7C, 1'b0);
        send_cmd(3'd7, 2'd3);
        tick();
        check("t4a_pending_code", op_code, 7'h7D);
        op_ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4a_op_valid", op_valid, 0);
        check("t4a_abort_done", abort_done, 1);
        check("t4a_cmd_ready", cmd_ready, 1);
        check("t4a_cnt", issued_cnt, 8);
        tick();
        check("t4a_abort_done_one_cycle", abort_done, 0);

        // 4b: abort with handshake completes that beat
        op_ready = 1'b1;
        push(7'h7C, 1'b0); push(7'h7D, 1'b0);
        send_cmd(3'd7, 2'd3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4b_op_valid", op_valid, 0);
        check("t4b_abort_done", abort_done, 1);
        check("t4b_cnt", issued_cnt, 10);
        tick();
        check("t4b_abort_done_one_cycle", abort_done, 0);

        // 5: asynchronous reset mid-burst
        op_ready = 1'b0;
        send_cmd(3'd5, 2'd1);
        check("t5_busy", op_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_op_valid", op_valid, 0);
        check("t5_rst_cmd_ready", cmd_ready, 0);
        check("t5_rst_cnt", issued_cnt, 0);
        check("t5_rst_op_code", op_code, 0);
        tick();
        rst_n = 1'b1;
        op_ready = 1'b1;
        push(7'h08, 1'b0); push(7'h09, 1'b0); push(7'h0A, 1'b1);
        send_cmd(3'd2, 2'd0);
        wait_idle();
        check("t5_cnt", issued_cnt, 3);

        // 6: saturation of the issued counter
        for (int i = 0; i < 20; i++) begin
            logic [2:0] id;
            logic [1:0] arg;
            id  = (i % 2 == 0) ? 3'd0 : 3'd4;
            arg = 2'(i);
            push({arg, id, 2'b00}, 1'b1);
            send_cmd(id, arg);
            wait_idle();
            if (i == 11) check("t6_cnt_reaches_max", issued_cnt, 15);
        end
        check("t6_cnt_saturated", issued_cnt, 15);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_opcode_sequencer.md
Name: ctrl_opcode_sequencer

Overview:
Transmit-side counterpart of the combinational control-word decoder. It accepts macro commands over a valid/ready handshake and expands each one into a burst of 1-4 seven-bit micro-opcodes. The micro-opcodes are presented, one per handshake, on the 7-bit opcode bus {x6..x0} that the decoder consumes. The block also provides abort support and a saturating count of issued micro-ops.

Parameters:
CNT_W, 16, width of the issued-op counter (saturating)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  macro command offered
cmd_ready  output  1  block can accept a command
cmd_id  input  3  macro command identifier
cmd_arg  input  2  command argument
op_valid  output  1  micro-opcode valid
op_ready  input  1  downstream accepts micro-opcode
op_code  output  7  micro-opcode, bit i drives decoder input xi
op_last  output  1  final micro-op of the current command
abort  input  1  one-cycle request to cancel the current command
abort_done  output  1  one-cycle pulse when an abort takes effect
issued_cnt  output  CNT_W  count of completed op handshakes, saturates at all-ones

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). While rst_n=0: state=IDLE, cmd_ready=0, op_valid=0, op_code=0, op_last=0, abort_done=0, issued_cnt=0. cmd_ready rises on the first clock edge after reset is released.
- States: IDLE, ISSUE.
- IDLE:
  - cmd_ready=1 and op_valid=0.
  - On cmd_valid&cmd_ready: latch id and arg, set step=0, go to ISSUE.
  - op_valid rises on the next cycle (latency 1).
- Burst length: len(id) = (id mod 4)+1, giving 1..4 beats.
- Opcode encoding: op_code = {arg[1:0], id[2:0], step[1:0]}.
- ISSUE:
  - cmd_ready=0 and op_valid=1.
  - op_code and op_last stay stable until op_ready=1.
  - op_last = (step == len-1).
  - On handshake with op_last=0: step+1 and stay in ISSUE; the next beat appears the following cycle with no bubble.
  - On handshake with op_last=1: go to IDLE; op_valid=0 and cmd_ready=1 next cycle.
  - Minimum cost is len+1 cycles per command.
- Abort, in ISSUE only (abort in IDLE is ignored, no pulse):
  - If a handshake occurs in the same cycle, that beat completes and is counted; no further beats are issued.
  - If no handshake occurs, the pending beat is withdrawn: op_valid=0 next cycle. This is a permitted valid drop, abort only.
  - In both cases: go to IDLE and pulse abort_done=1 for exactly one cycle (the cycle after abort).
  - If abort coincides with the op_last handshake, the command completes normally and abort_done still pulses.
- issued_cnt: +1 on every op handshake and holds at 2^CNT_W-1. It is not cleared by abort.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous). The partial burst is lost and is not resumed.
- cmd_id and cmd_arg are sampled only on the command handshake; later changes have no effect on the burst in progress.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum typedef (IDLE, ISSUE);
  - the field widths OPC_W=7, ID_W=3, ARG_W=2, STEP_W=2;
  - function burst_len(id);
  - function pack_opcode(arg,id,step).
- No sub-module is needed. The saturating counter is a small always block; an optional sat_counter sub-module is allowed.

Test Plan:
1. Reset released; cmd id=0 arg=0 with op_ready=1 -> single beat op_code=0x00, op_last=1; cmd_ready high again 2 cycles after accept; issued_cnt=1.
2. id=3 arg=2, op_ready=1 -> beats 0x4C,0x4D,0x4E,0x4F on consecutive cycles; op_last only on 0x4F; issued_cnt=4.
3. id=1 arg=0, op_ready low for 3 cycles at beat 2 -> 0x04 accepted, then 0x05 held stable with op_valid=1 for 3 cycles; op_last=1 on 0x05.
4. id=7 arg=3 (0x7C..0x7F); accept 0x7C; abort at 0x7D with op_ready=0 -> op_valid=0 next cycle, abort_done pulses once, issued_cnt=1, cmd_ready=1. Repeat with op_ready=1 at the abort -> issued_cnt=2.
5. rst_n pulled low mid-burst with no clock edge -> op_valid, cmd_ready and issued_cnt go to 0 immediately; after release, a new command id=2 issues 0x08,0x09,0x0A.
6. CNT_W=4, issue 20 single-beat commands -> issued_cnt stops at 15 and does not wrap.
